// File: rtl/tr_pkg.sv
// Shared state encoding, owner codes and default timing for the step scheduler.
package tr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EN_LEAD   = 3'd1,
    ST_DIR_SETUP = 3'd2,
    ST_HIGH      = 3'd3,
    ST_LOW       = 3'd4,
    ST_HOLD      = 3'd5
  } state_t;

  localparam logic OWNER_AUTO = 1'b0;
  localparam logic OWNER_JOG  = 1'b1;

  localparam int DEF_CNT_W       = 12;
  localparam int DEF_PER_W       = 16;
  localparam int DEF_PER_MIN     = 1000;
  localparam int DEF_T_PULSE     = 50;
  localparam int DEF_T_EN_LEAD   = 50;
  localparam int DEF_T_DIR_SETUP = 10;
  localparam int DEF_T_IDLE_OFF  = 5000;
  localparam int DEF_PER_START   = 4000;
  localparam int DEF_RAMP_DEC    = 250;

  // Timer reload for a phase lasting `cycles`: the load itself is registered
  // and the terminal-zero cycle counts, hence the two-cycle offset.
  function automatic int phase_load(input int cycles);
    return cycles - 2;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter shared by every timed phase of the step scheduler.
module step_timer
  import tr_pkg::*;
#(
  parameter int W = DEF_PER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         expired
);

  logic [W-1:0] cnt_r;

  // Count down to zero and park there until reloaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == '0);

endmodule

// File: rtl/step_sched.sv
// Stepper step scheduler: jog/auto arbitration and driver pin sequencing.
// Optional trapezoidal speed ramp enabled by defining STEP_SCHED_RAMP_EN.
module step_sched
  import tr_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PER_W       = DEF_PER_W,
  parameter int PER_MIN     = DEF_PER_MIN,
  parameter int T_PULSE     = DEF_T_PULSE,
  parameter int T_EN_LEAD   = DEF_T_EN_LEAD,
  parameter int T_DIR_SETUP = DEF_T_DIR_SETUP,
  parameter int T_IDLE_OFF  = DEF_T_IDLE_OFF,
  parameter int PER_START   = DEF_PER_START,
  parameter int RAMP_DEC    = DEF_RAMP_DEC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             auto_req,
  input  logic             auto_dir,
  input  logic [CNT_W-1:0] auto_steps,
  output logic             auto_ack,
  input  logic             jog_req,
  input  logic             jog_dir,
  input  logic [CNT_W-1:0] jog_steps,
  output logic             jog_ack,
  output logic             drv_SM,
  output logic             drv_step,
  output logic             drv_dir,
  output logic             busy,
  output logic             owner,
  output logic             done,
  output logic [CNT_W-1:0] steps_done
);

`ifdef STEP_SCHED_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  localparam logic [PER_W-1:0] LD_LEAD  = PER_W'(phase_load(T_EN_LEAD));
  localparam logic [PER_W-1:0] LD_SETUP = PER_W'(phase_load(T_DIR_SETUP));
  localparam logic [PER_W-1:0] LD_PULSE = PER_W'(phase_load(T_PULSE));
  localparam logic [PER_W-1:0] LD_IDLE  = PER_W'(phase_load(T_IDLE_OFF));
  localparam logic [PER_W-1:0] LOW_ADJ  = PER_W'(T_PULSE + 2);
  localparam logic [PER_W-1:0] P_MIN    = PER_W'(PER_MIN);
  localparam logic [PER_W-1:0] P_START  = PER_W'(PER_START);
  localparam logic [PER_W-1:0] P_DEC    = PER_W'(RAMP_DEC);
  localparam logic [PER_W-1:0] P_FIRST  = RAMP ? P_START : P_MIN;

  state_t           state_r;
  logic [CNT_W-1:0] rem_r, k_r, gnt_steps_s;
  logic [PER_W-1:0] per_r, tmr_val_r, per_next_s;
  logic             tmr_load_r, tmr_raw_s, tmr_exp_s;
  logic             abort_r, zdone_r, mv_dir_r;
  logic             gnt_s, gnt_jog_s, gnt_dir_s, k_inc_s;

  step_timer #(.W(PER_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load_r),
    .val     (tmr_val_r),
    .expired (tmr_raw_s)
  );

  // A pending reload makes the counter's current zero stale.
  assign tmr_exp_s = tmr_raw_s & ~tmr_load_r;

  // Fixed-priority grant: jog beats auto, only at rest with run permit.
  always_comb begin
    gnt_s       = 1'b0;
    gnt_jog_s   = 1'b0;
    gnt_dir_s   = auto_dir;
    gnt_steps_s = auto_steps;
    if (enable && !zdone_r && (state_r == ST_IDLE || state_r == ST_HOLD)) begin
      if (jog_req) begin
        gnt_s       = 1'b1;
        gnt_jog_s   = 1'b1;
        gnt_dir_s   = jog_dir;
        gnt_steps_s = jog_steps;
      end else if (auto_req) begin
        gnt_s = 1'b1;
      end else begin
        gnt_s = 1'b0;
      end
    end else begin
      gnt_s = 1'b0;
    end
  end

  // Next period: speed up only while enough steps remain to slow back down.
  always_comb begin
    per_next_s = per_r;
    k_inc_s    = 1'b0;
    if (RAMP) begin
      if ((rem_r - CNT_W'(1)) > k_r) begin
        if (per_r >= P_MIN + P_DEC) begin
          per_next_s = per_r - P_DEC;
          k_inc_s    = 1'b1;
        end else if (per_r > P_MIN) begin
          per_next_s = P_MIN;
          k_inc_s    = 1'b1;
        end else begin
          per_next_s = P_MIN;
        end
      end else if (per_r + P_DEC < P_START) begin
        per_next_s = per_r + P_DEC;
      end else begin
        per_next_s = P_START;
      end
    end else begin
      per_next_s = P_MIN;
    end
  end

  // Move sequencer; every driver pin and status output is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      drv_SM     <= 1'b0;
      drv_step   <= 1'b0;
      drv_dir    <= 1'b0;
      busy       <= 1'b0;
      owner      <= OWNER_AUTO;
      done       <= 1'b0;
      steps_done <= '0;
      auto_ack   <= 1'b0;
      jog_ack    <= 1'b0;
      rem_r      <= '0;
      k_r        <= '0;
      per_r      <= P_FIRST;
      tmr_load_r <= 1'b0;
      tmr_val_r  <= '0;
      abort_r    <= 1'b0;
      zdone_r    <= 1'b0;
      mv_dir_r   <= 1'b0;
    end else begin
      auto_ack   <= 1'b0;
      jog_ack    <= 1'b0;
      tmr_load_r <= 1'b0;
      zdone_r    <= 1'b0;
      done       <= zdone_r;
      if (gnt_s) begin
        auto_ack   <= ~gnt_jog_s;
        jog_ack    <= gnt_jog_s;
        owner      <= gnt_jog_s ? OWNER_JOG : OWNER_AUTO;
        steps_done <= '0;
        rem_r      <= gnt_steps_s;
        per_r      <= P_FIRST;
        k_r        <= '0;
        abort_r    <= 1'b0;
        mv_dir_r   <= gnt_dir_s;
        if (gnt_steps_s == '0) begin
          zdone_r    <= 1'b1;
          tmr_load_r <= (state_r == ST_HOLD);
          tmr_val_r  <= LD_IDLE;
        end else if (state_r == ST_IDLE) begin
          state_r    <= ST_EN_LEAD;
          drv_SM     <= 1'b1;
          busy       <= 1'b1;
          tmr_load_r <= 1'b1;
          tmr_val_r  <= LD_LEAD;
        end else if (gnt_dir_s != drv_dir) begin
          state_r    <= ST_DIR_SETUP;
          drv_dir    <= gnt_dir_s;
          busy       <= 1'b1;
          tmr_load_r <= 1'b1;
          tmr_val_r  <= LD_SETUP;
        end else begin
          state_r    <= ST_HIGH;
          drv_step   <= 1'b1;
          busy       <= 1'b1;
          steps_done <= CNT_W'(1);
          rem_r      <= gnt_steps_s - CNT_W'(1);
          tmr_load_r <= 1'b1;
          tmr_val_r  <= LD_PULSE;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            drv_SM <= 1'b0;
            busy   <= 1'b0;
          end
          ST_HOLD: begin
            if (!enable || tmr_exp_s) begin
              state_r <= ST_IDLE;
              drv_SM  <= 1'b0;
            end else begin
              state_r <= ST_HOLD;
            end
          end
          ST_EN_LEAD: begin
            if (!enable) begin
              state_r <= ST_IDLE;
              drv_SM  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (tmr_exp_s) begin
              state_r    <= ST_DIR_SETUP;
              drv_dir    <= mv_dir_r;
              tmr_load_r <= 1'b1;
              tmr_val_r  <= LD_SETUP;
            end else begin
              state_r <= ST_EN_LEAD;
            end
          end
          ST_DIR_SETUP: begin
            if (!enable) begin
              state_r <= ST_IDLE;
              drv_SM  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (tmr_exp_s) begin
              state_r    <= ST_HIGH;
              drv_step   <= 1'b1;
              steps_done <= steps_done + CNT_W'(1);
              rem_r      <= rem_r - CNT_W'(1);
              tmr_load_r <= 1'b1;
              tmr_val_r  <= LD_PULSE;
            end else begin
              state_r <= ST_DIR_SETUP;
            end
          end
          ST_HIGH: begin
            abort_r <= abort_r | ~enable;
            if (tmr_exp_s) begin
              drv_step <= 1'b0;
              if (abort_r || !enable) begin
                state_r <= ST_IDLE;
                drv_SM  <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state_r    <= ST_LOW;
                tmr_load_r <= 1'b1;
                tmr_val_r  <= per_r - LOW_ADJ;
              end
            end else begin
              state_r <= ST_HIGH;
            end
          end
          ST_LOW: begin
            if (!enable) begin
              state_r <= ST_IDLE;
              drv_SM  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (tmr_exp_s && rem_r != '0) begin
              state_r    <= ST_HIGH;
              drv_step   <= 1'b1;
              steps_done <= steps_done + CNT_W'(1);
              rem_r      <= rem_r - CNT_W'(1);
              per_r      <= per_next_s;
              k_r        <= k_r + CNT_W'(k_inc_s);
              tmr_load_r <= 1'b1;
              tmr_val_r  <= LD_PULSE;
            end else if (tmr_exp_s) begin
              state_r    <= ST_HOLD;
              busy       <= 1'b0;
              done       <= 1'b1;
              tmr_load_r <= 1'b1;
              tmr_val_r  <= LD_IDLE;
            end else begin
              state_r <= ST_LOW;
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            drv_SM   <= 1'b0;
            drv_step <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
